mux2_1_3bits: RTL and testbench
===============================

// Module: mux2_1_3bits
//
// PURPOSE
// - 2:1 multiplexer for 3-bit fields in the multi-cycle 16-bit RISC datapath,
//   e.g. register-address selection.
// - Output is combinational and drives downstream datapath logic in the same cycle.
// - A registered copy of the output and of the select is also provided, for
//   multi-cycle control paths and for debug/observation.
// - One clock domain; asynchronous active-high reset clears only the registered copies.
//
// PARAMETERS
// - WIDTH    default 3   data width of I0, I1, Output and Output_r
//
// PORTS
// - Clock     in   1      rising-edge clock; captures Output_r and S_r
// - Reset     in   1      asynchronous, active-high; clears Output_r and S_r
// - I0        in   WIDTH  data input, selected when S=0
// - I1        in   WIDTH  data input, selected when S=1
// - S         in   1      select
// - Output    out  WIDTH  combinational mux result
// - Output_r  out  WIDTH  Output registered on the Clock rising edge
// - S_r       out  1      S registered on the Clock rising edge
//
// BEHAVIOUR
// - Combinational output:
//   - Output = S ? I1 : I0, zero latency, no dependence on Clock or Reset.
//   - Output follows every change on I0, I1 or S with no clock edge.
//   - Output stays valid while Reset is asserted.
// - The unselected input has no effect on Output. Example: S=0, I1 toggling
//   leaves Output = I0.
// - Registered outputs:
//   - On each Clock rising edge with Reset=0: Output_r <= (S ? I1 : I0), S_r <= S.
//   - Latency is 1 cycle relative to Output.
// - Reset:
//   - When Reset goes high, Output_r = {WIDTH{1'b0}} and S_r = 0 immediately,
//     with no clock edge needed.
//   - Both stay at these values while Reset=1.
//   - The first rising edge after Reset deasserts captures normally.
//   - Reset asserted mid-operation discards the held value; no partial update.
// - Power-up: Output_r and S_r are undefined until the first Reset assertion.
//   The bench asserts Reset at time 0.
// - Widths: all data paths are exactly WIDTH bits, with no extension or truncation.
//   Values 0..2^WIDTH-1 pass unchanged (0..7 for WIDTH=3).
// - S=X/Z: no requirement in synthesis. In simulation Output may be X.
// - No handshake and no enable. The block is purely a select plus a pipeline copy.
//
// TESTING
// - Reset=1 at t=0 for 100 ns, I0=I1=0, S=0
//   -> Output=0, Output_r=0, S_r=0 throughout.
// - S=0, I1=0, I0 stepped 0..7 every 20 ns
//   -> Output equals I0 within each step; Output_r equals I0 one Clock edge later.
// - S=1, I0=0, I1 stepped 0..7 every 20 ns
//   -> Output equals I1 each step; S_r=1 after the first edge.
// - S=0, I0=3'b101, I1 toggled 3'b010 <-> 3'b111
//   -> Output constant 3'b101; then S=1 -> Output follows I1 immediately.
// - Running with Output_r=3'b110, pulse Reset between Clock edges
//   -> Output_r=0 and S_r=0 asynchronously while Output still equals S?I1:I0;
//      the next edge after release reloads Output_r.
// - WIDTH=8 build, I0=8'hA5, I1=8'h3C, S toggled
//   -> Output alternates 8'hA5 / 8'h3C with no truncation.

Source files
------------

// File: rtl/mux2_1_3bits.sv
// mux2_1_3bits: 2:1 select for narrow datapath fields (e.g. register
// addresses), with a registered copy of the result and of the select for
// multi-cycle control paths and debug observation.
module mux2_1_3bits #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Output_r,
  output logic             S_r
);

  logic [WIDTH-1:0] sel;

  // Zero-latency select; independent of Clock and Reset.
  always_comb begin
    sel = S ? I1 : I0;
  end

  assign Output = sel;

  // Pipeline copy of the selected value and the select; reset clears both at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Output_r <= '0;
      S_r      <= 1'b0;
    end else begin
      Output_r <= sel;
      S_r      <= S;
    end
  end

endmodule

// File: tb/tb_mux2_1_3bits.sv
// tb_mux2_1_3bits: directed vectors drive both a default (3-bit) and an
// 8-bit instance; expected values are queued and checked by a monitor.
module tb_mux2_1_3bits;

  logic       Clock;
  logic       Reset;
  logic [2:0] i0, i1;
  logic       s;
  logic [2:0] out3, out3_r;
  logic       s3_r;

  logic [7:0] a8, b8;
  logic       s8;
  logic [7:0] out8, out8_r;
  logic       s8_r;

  mux2_1_3bits dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .I0       (i0),
    .I1       (i1),
    .S        (s),
    .Output   (out3),
    .Output_r (out3_r),
    .S_r      (s3_r)
  );

  mux2_1_3bits #(.WIDTH(8)) dut8 (
    .Clock    (Clock),
    .Reset    (Reset),
    .I0       (a8),
    .I1       (b8),
    .S        (s8),
    .Output   (out8),
    .Output_r (out8_r),
    .S_r      (s8_r)
  );

  typedef struct {
    string       name;
    int unsigned which;
    int unsigned idx;
    logic [7:0]  exp;
  } chk_t;

  chk_t        q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned vec     = 0;

  initial begin
    Clock = 1'b0;
    forever #10 Clock = ~Clock;
  end

  task automatic expect_val(input string nm, input int unsigned w, input logic [7:0] e);
    chk_t c;
    c.name  = nm;
    c.which = w;
    c.idx   = vec;
    c.exp   = e;
    q.push_back(c);
  endtask

  // Apply one vector just after a rising edge; expectations are checked at the next falling edge.
  task automatic apply(input logic [2:0] v0, input logic [2:0] v1, input logic vs, input logic vr,
                       input logic [2:0] eo, input logic [2:0] er, input logic es);
    @(posedge Clock);
    #2;
    i0 = v0; i1 = v1; s = vs; Reset = vr;
    expect_val("output",   0, {5'b0, eo});
    expect_val("output_r", 1, {5'b0, er});
    expect_val("s_r",      2, {7'b0, es});
    vec++;
  endtask

  task automatic apply8(input logic vs, input logic [7:0] eo, input logic [7:0] er);
    @(posedge Clock);
    #2;
    s8 = vs;
    expect_val("w8_output",   3, eo);
    expect_val("w8_output_r", 4, er);
    vec++;
  endtask

  // Monitor: outputs are stable mid-cycle, so every pending expectation is compared on the falling edge.
  always @(negedge Clock) begin
    chk_t       c;
    logic [7:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.which)
        0:       act = {5'b0, out3};
        1:       act = {5'b0, out3_r};
        2:       act = {7'b0, s3_r};
        3:       act = out8;
        default: act = out8_r;
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s vec %0d: got %h expected %h", c.name, c.idx, act, c.exp);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    i0 = '0; i1 = '0; s = 1'b0;
    a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;

    // Reset held: registered copies stay cleared while Output keeps selecting.
    //     I0    I1    S  Rst  Out   Out_r S_r
    apply(3'd0, 3'd0, 0, 1, 3'd0, 3'd0, 0);
    apply(3'd0, 3'd0, 0, 1, 3'd0, 3'd0, 0);
    apply(3'd0, 3'd0, 0, 1, 3'd0, 3'd0, 0);
    apply(3'd0, 3'd7, 1, 1, 3'd7, 3'd0, 0);
    apply(3'd0, 3'd7, 1, 1, 3'd7, 3'd0, 0);
    // Release between edges: nothing captured yet.
    apply(3'd0, 3'd0, 0, 0, 3'd0, 3'd0, 0);

    // S=0, I0 stepped, I1 parked at 6 (unselected).
    apply(3'd0, 3'd6, 0, 0, 3'd0, 3'd0, 0);
    apply(3'd1, 3'd6, 0, 0, 3'd1, 3'd0, 0);
    apply(3'd2, 3'd6, 0, 0, 3'd2, 3'd1, 0);
    apply(3'd3, 3'd6, 0, 0, 3'd3, 3'd2, 0);
    apply(3'd4, 3'd6, 0, 0, 3'd4, 3'd3, 0);
    apply(3'd5, 3'd6, 0, 0, 3'd5, 3'd4, 0);
    apply(3'd6, 3'd6, 0, 0, 3'd6, 3'd5, 0);
    apply(3'd7, 3'd6, 0, 0, 3'd7, 3'd6, 0);

    // S=1, I0=0, I1 stepped.
    apply(3'd0, 3'd0, 1, 0, 3'd0, 3'd7, 0);
    apply(3'd0, 3'd1, 1, 0, 3'd1, 3'd0, 1);
    apply(3'd0, 3'd2, 1, 0, 3'd2, 3'd1, 1);
    apply(3'd0, 3'd3, 1, 0, 3'd3, 3'd2, 1);
    apply(3'd0, 3'd4, 1, 0, 3'd4, 3'd3, 1);
    apply(3'd0, 3'd5, 1, 0, 3'd5, 3'd4, 1);
    apply(3'd0, 3'd6, 1, 0, 3'd6, 3'd5, 1);
    apply(3'd0, 3'd7, 1, 0, 3'd7, 3'd6, 1);

    // S=0, I0=101, I1 toggling 010/111: Output stays 101; then S=1 follows I1.
    apply(3'd5, 3'd2, 0, 0, 3'd5, 3'd7, 1);
    apply(3'd5, 3'd7, 0, 0, 3'd5, 3'd5, 0);
    apply(3'd5, 3'd2, 0, 0, 3'd5, 3'd5, 0);
    apply(3'd5, 3'd7, 1, 0, 3'd7, 3'd5, 0);
    apply(3'd5, 3'd2, 1, 0, 3'd2, 3'd7, 1);

    // Build up Output_r=110, then pulse Reset mid-cycle.
    apply(3'd6, 3'd1, 0, 0, 3'd6, 3'd2, 1);
    apply(3'd6, 3'd1, 0, 0, 3'd6, 3'd6, 0);
    apply(3'd6, 3'd1, 1, 1, 3'd1, 3'd0, 0);
    apply(3'd6, 3'd1, 1, 0, 3'd1, 3'd0, 0);
    apply(3'd3, 3'd4, 0, 0, 3'd3, 3'd1, 1);
    apply(3'd3, 3'd4, 0, 0, 3'd3, 3'd3, 0);

    // 8-bit instance: I0=A5, I1=3C, S toggled.
    apply8(1'b1, 8'h3C, 8'hA5);
    apply8(1'b0, 8'hA5, 8'h3C);
    apply8(1'b1, 8'h3C, 8'hA5);
    apply8(1'b0, 8'hA5, 8'h3C);

    // Drain: bounded wait for the monitor to consume every expectation.
    repeat (3) @(posedge Clock);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
